// File: rtl/ysyx_24090012_icache_param_if.sv
// ysyx_24090012_icache_param_if: fetch request/response, AXI4 read channel and perf counters of the icache.
interface ysyx_24090012_icache_param_if;
  logic        req_valid, req_ready, kill, fence_i;
  logic [31:0] req_addr;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_inst, resp_pc;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready, rlast;
  logic [31:0] rdata;
  logic [3:0]  rid;
  logic [1:0]  rresp;
  logic [31:0] hit_cnt, miss_cnt;
  modport master (
    input  req_valid, req_addr, kill, fence_i, resp_ready, arready, rvalid, rdata, rid, rresp, rlast,
    output req_ready, resp_valid, resp_inst, resp_pc, resp_err, arvalid, araddr, arid, arlen, arsize,
           arburst, rready, hit_cnt, miss_cnt
  );
  modport slave (
    output req_valid, req_addr, kill, fence_i, resp_ready, arready, rvalid, rdata, rid, rresp, rlast,
    input  req_ready, resp_valid, resp_inst, resp_pc, resp_err, arvalid, araddr, arid, arlen, arsize,
           arburst, rready, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/ysyx_24090012_icache_param.sv
// ysyx_24090012_icache_param: direct-mapped icache with AXI4 INCR line refill, fence.i, kill draining.
// Define ICACHE_PERF_EN to build the hit/miss counters; otherwise they read as 0.
module ysyx_24090012_icache_param #(
  parameter int          LINES    = 4,
  parameter int          WORDS    = 4,
  parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
  input logic clock,
  input logic reset,
  ysyx_24090012_icache_param_if.master bus
);
  localparam int INDEX_BITS  = $clog2(LINES);
  localparam int WORD_BITS   = $clog2(WORDS);
  localparam int OFFSET_BITS = WORD_BITS + 2;
  localparam int TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS;
  typedef enum logic [2:0] {IDLE, LOOKUP, AR, R, RESP} state_t;
  state_t state, state_n;
  logic [TAG_BITS-1:0]   tags [LINES];
  logic [31:0]           data [LINES][WORDS];
  logic [31:0]           linebuf [WORDS];
  logic [LINES-1:0]      valid;
  logic [31:0]           pc_q;
  logic [3:0]            cur_id;
  logic [WORD_BITS-1:0]  beat_cnt;
  logic                  killed_q, err_q, fence_pend;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic [WORD_BITS-1:0]  woff;
  logic                  hit, beat_ok, install, miss, fence_now;
  assign idx       = pc_q[OFFSET_BITS +: INDEX_BITS];
  assign tag       = pc_q[31 -: TAG_BITS];
  assign woff      = pc_q[2 +: WORD_BITS];
  assign hit       = valid[idx] && tags[idx] == tag;
  assign miss      = state == LOOKUP && !bus.kill && !hit;
  assign beat_ok   = state == R && bus.rvalid && bus.rid == cur_id;
  assign install   = beat_ok && bus.rlast && !err_q && bus.rresp == 2'b00;
  // A fence seen mid-refill is deferred so it also wipes the line the refill installs.
  assign fence_now = (bus.fence_i && (state == IDLE || state == LOOKUP)) || (state == IDLE && fence_pend);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = bus.req_valid && bus.req_ready ? LOOKUP : IDLE;
      LOOKUP:  state_n = bus.kill ? IDLE : !hit ? AR : bus.resp_ready ? IDLE : LOOKUP;
      AR:      state_n = bus.arready ? R : AR;
      R:       state_n = beat_ok && bus.rlast ? (killed_q || bus.kill ? IDLE : RESP) : R;
      RESP:    state_n = bus.kill || bus.resp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
    bus.req_ready  = state == IDLE && !bus.kill;
    bus.resp_valid = !bus.kill && ((state == LOOKUP && hit) || state == RESP);
    bus.resp_inst  = state == LOOKUP ? data[idx][woff] : state == RESP ? linebuf[woff] : 32'h0;
    bus.resp_pc    = pc_q;
    bus.resp_err   = state == RESP && err_q;
    bus.arvalid    = state == AR;
    bus.araddr     = {pc_q[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    bus.arid       = cur_id;
    bus.arlen      = 8'(WORDS - 1);
    bus.arsize     = 3'b010;
    bus.arburst    = 2'b01;
    bus.rready     = state == R;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      valid      <= '0;
      cur_id     <= '0;
      beat_cnt   <= '0;
      killed_q   <= 1'b0;
      err_q      <= 1'b0;
      fence_pend <= 1'b0;
      pc_q       <= RESET_PC;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.req_valid && bus.req_ready) pc_q <= bus.req_addr;
      if (miss) begin
        cur_id   <= cur_id + 4'd1;
        beat_cnt <= '0;
        killed_q <= 1'b0;
        err_q    <= 1'b0;
      end
      if ((state == AR || state == R) && bus.kill) killed_q <= 1'b1;
      if (state == R && bus.rvalid && bus.rresp != 2'b00) err_q <= 1'b1;
      if (beat_ok) beat_cnt <= beat_cnt + 1'b1;
      if (install) valid[idx] <= 1'b1;
      if (bus.fence_i && state != IDLE && state != LOOKUP) fence_pend <= 1'b1;
      if (fence_now) begin
        valid      <= '0;
        fence_pend <= 1'b0;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (beat_ok) linebuf[beat_cnt] <= bus.rdata;
    if (install) begin
      tags[idx] <= tag;
      for (int w = 0; w < WORDS; w++) data[idx][w] <= WORD_BITS'(w) == beat_cnt ? bus.rdata : linebuf[w];
    end
  end
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_q, miss_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (state == LOOKUP && !bus.kill) begin
      hit_q  <= hit_q + 32'(hit && bus.resp_ready);
      miss_q <= miss_q + 32'(!hit);
    end
  end
  assign bus.hit_cnt  = hit_q;
  assign bus.miss_cnt = miss_q;
`else
  assign bus.hit_cnt  = '0;
  assign bus.miss_cnt = '0;
`endif
endmodule

// File: tb/tb_ysyx_24090012_icache_param.sv
// tb_ysyx_24090012_icache_param: directed fetch sequences against a small AXI memory for the icache.
module tb_ysyx_24090012_icache_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  int n_hits = 0;
  int n_misses = 0;
  logic [3:0] exp_id = 4'd0;
`ifdef ICACHE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  ysyx_24090012_icache_param_if bus ();
  ysyx_24090012_icache_param dut (.clock(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h11 * (32'(a[3:2]) + 32'd1) + 32'(a[15:4]);
  endfunction
  task automatic fetch(input string tag, input logic [31:0] addr, input bit hit, input logic [31:0] inst,
                       input int err_beat = -1, input int kill_beat = -1, input int fence_beat = -1,
                       input int stall = 0, input bit stray = 1'b0);
    logic [31:0] base;
    base = {addr[31:4], 4'h0};
    check({tag, "/req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    tick();
    bus.req_valid = 1'b0;
    check({tag, "/lookup_valid"}, 32'(bus.resp_valid), 32'(hit));
    if (hit) begin
      n_hits++;
      check({tag, "/hit_inst"}, bus.resp_inst, inst);
      check({tag, "/hit_pc"}, bus.resp_pc, addr);
      tick();
      return;
    end
    n_misses++;
    exp_id = exp_id + 4'd1;
    tick();
    check({tag, "/arvalid"}, 32'(bus.arvalid), 32'd1);
    check({tag, "/araddr"}, bus.araddr, base);
    check({tag, "/arid"}, 32'(bus.arid), 32'(exp_id));
    check({tag, "/arlen"}, {bus.arlen, bus.arsize, bus.arburst}, {8'd3, 3'b010, 2'b01});
    tick();
    check({tag, "/arvalid_held"}, 32'(bus.arvalid), 32'd1);
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0;
    if (stray) begin
      bus.rvalid = 1'b1; bus.rid = exp_id ^ 4'hA; bus.rdata = 32'hdead_beef; bus.rlast = 1'b1; bus.rresp = 2'b00;
      tick();
    end
    for (int b = 0; b < 4; b++) begin
      check({tag, "/rready"}, 32'(bus.rready), 32'd1);
      bus.rvalid  = 1'b1;
      bus.rid     = exp_id;
      bus.rdata   = mem(base | 32'(b * 4));
      bus.rresp   = b == err_beat ? 2'b10 : 2'b00;
      bus.rlast   = b == 3;
      bus.kill    = b == kill_beat;
      bus.fence_i = b == fence_beat;
      tick();
    end
    bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.rresp = 2'b00; bus.kill = 1'b0; bus.fence_i = 1'b0;
    if (kill_beat >= 0) begin
      check({tag, "/killed_no_resp"}, 32'(bus.resp_valid), 32'd0);
      check({tag, "/killed_idle"}, 32'(bus.req_ready), 32'd1);
      return;
    end
    check({tag, "/resp_valid"}, 32'(bus.resp_valid), 32'd1);
    check({tag, "/resp_inst"}, bus.resp_inst, inst);
    check({tag, "/resp_err"}, 32'(bus.resp_err), 32'(err_beat >= 0));
    check({tag, "/resp_pc"}, bus.resp_pc, addr);
    if (stall > 0) begin
      bus.resp_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        tick();
        check({tag, "/stall_valid"}, 32'(bus.resp_valid), 32'd1);
        check({tag, "/stall_inst"}, bus.resp_inst, inst);
        check({tag, "/stall_req_ready"}, 32'(bus.req_ready), 32'd0);
      end
      bus.resp_ready = 1'b1;
    end
    tick();
    check({tag, "/done_idle"}, 32'(bus.req_ready), 32'd1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.kill = 1'b0; bus.fence_i = 1'b0; bus.resp_ready = 1'b1;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rid = '0; bus.rresp = '0; bus.rlast = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst/req_ready", 32'(bus.req_ready), 32'd1);
    check("rst/resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst/resp_inst", bus.resp_inst, 32'd0);
    check("rst/resp_err", 32'(bus.resp_err), 32'd0);
    check("rst/resp_pc", bus.resp_pc, 32'h3000_0000);
    check("rst/arvalid", 32'(bus.arvalid), 32'd0);
    check("rst/rready", 32'(bus.rready), 32'd0);
    check("rst/hit_cnt", bus.hit_cnt, 32'd0);
    check("rst/miss_cnt", bus.miss_cnt, 32'd0);
    fetch("cold", 32'h3000_0000, 1'b0, 32'h11, .stray(1'b1));
    fetch("rehit", 32'h3000_0008, 1'b1, 32'h33);
    fetch("evict", 32'h3000_0040, 1'b0, 32'h15);
    fetch("reload", 32'h3000_0000, 1'b0, 32'h11);
    check("cnt/hit", bus.hit_cnt, PERF ? 32'd1 : 32'd0);
    check("cnt/miss", bus.miss_cnt, PERF ? 32'd3 : 32'd0);
    fetch("kill", 32'h3000_0014, 1'b0, 32'h23, .kill_beat(2));
    fetch("kill_hit", 32'h3000_0014, 1'b1, 32'h23);
    fetch("err", 32'h3000_0024, 1'b0, 32'h24, .err_beat(1));
    fetch("err_refetch", 32'h3000_0024, 1'b0, 32'h24);
    fetch("fence_r", 32'h3000_0030, 1'b0, 32'h14, .fence_beat(1));
    fetch("fence_r_miss", 32'h3000_0030, 1'b0, 32'h14);
    fetch("pre_fence_hit", 32'h3000_0030, 1'b1, 32'h14);
    bus.fence_i = 1'b1;
    tick();
    bus.fence_i = 1'b0;
    fetch("fence_idle_miss", 32'h3000_0030, 1'b0, 32'h14);
    fetch("stall", 32'h3000_0138, 1'b0, 32'h46, .stall(5));
    check("cnt/hit_end", bus.hit_cnt, PERF ? 32'(n_hits) : 32'd0);
    check("cnt/miss_end", bus.miss_cnt, PERF ? 32'(n_misses) : 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ysyx_24090012_icache_param.md
# ysyx_24090012_icache_param

Parametrised direct-mapped instruction cache between the IFU fetch front-end and the AXI4 read master. It accepts one fetch address at a time and returns the 32-bit instruction. Misses refill a whole line with an INCR burst. It also provides fence.i invalidation, kill on control hazard with safe burst draining, and bus error reporting.

## Interface
- `LINES`, 4: number of cache lines; power of two, ≥2; `INDEX_BITS = log2(LINES)`.
- `WORDS`, 4: 32-bit words per line; one of 2/4/8; `OFFSET_BITS = log2(WORDS)+2`; `TAG_BITS = 32-INDEX_BITS-OFFSET_BITS`.
- `RESET_PC`, 32'h3000_0000: value reported on `resp_pc` before the first request.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: fetch request.
- `req_ready` out 1: `state==IDLE && !kill`.
- `req_addr` in 32: fetch PC; bits [1:0] ignored.
- `kill` in 1: control-hazard squash of the in-flight fetch.
- `fence_i` in 1: one-cycle pulse; invalidate all lines.
- `resp_valid` out 1: instruction valid.
- `resp_ready` in 1: downstream (IDU) accepts.
- `resp_inst` out 32: instruction word.
- `resp_pc` out 32: PC of `resp_inst`.
- `resp_err` out 1: refill saw a non-OKAY `rresp`.
- `arvalid` out 1, `arready` in 1, `araddr` out 32, `arid` out 4, `arlen` out 8, `arsize` out 3, `arburst` out 2: AXI4 read address.
- `rvalid` in 1, `rready` out 1, `rdata` in 32, `rid` in 4, `rresp` in 2, `rlast` in 1: AXI4 read data.
- `hit_cnt` out 32, `miss_cnt` out 32: performance counters.

## Operation
States:
- IDLE → LOOKUP on `req_valid && req_ready`; latch `req_addr` into `pc_q`.
- LOOKUP, hit: drive `resp_valid=1` with the selected word. On `resp_ready` go to IDLE; otherwise stay in LOOKUP.
- LOOKUP, miss: go to AR and increment `cur_id` (4-bit, wraps 15→0).
- AR: `arvalid=1`, `araddr={pc_q[31:OFFSET_BITS], 0}`, `arid=cur_id`, `arlen=WORDS-1`, `arsize=3'b010`, `arburst=2'b01`. Go to R on `arready`.
- R: `rready=1`.
  - Beats with `rid!=cur_id` are accepted and discarded.
  - Matching beats are written to `linebuf[beat_cnt]` and `beat_cnt` increments.
  - Any `rresp!=0` sets `err_q`.
  - On the matching `rlast`: if `!err_q` and no error on this beat, install tag, valid and data at the index. Then go to RESP, or to IDLE if `killed_q`.
- RESP: `resp_valid=1`, `resp_inst=linebuf[pc_q word offset]`, `resp_err=err_q`. On `resp_ready` go to IDLE.
- Word select is `pc_q[OFFSET_BITS-1:2]`.

Kill:
- In LOOKUP or RESP: go to IDLE next cycle; no handshake occurs, even if `resp_ready` is high the same cycle.
- In AR or R: set `killed_q`. AR keeps `arvalid` held until `arready` (AXI rule). R drains all beats and installs the line if error-free, then returns to IDLE with no response.
- In IDLE: no effect; `req_ready` is 0 that cycle.

Fence.i:
- In IDLE or LOOKUP: clears all valid bits at the clock edge.
- Otherwise: sets `fence_pend`. All valid bits are cleared on the first cycle back in IDLE, after any install, so the refilled line is also invalidated.

Reset:
- `state=IDLE`, all valid bits 0, `cur_id=0`, `beat_cnt=0`, `killed_q=0`, `err_q=0`, `fence_pend=0`, `pc_q=RESET_PC`.
- Outputs: `req_ready=1`, `resp_valid=0`, `resp_inst=0`, `resp_err=0`, `arvalid=0`, `rready=0`, counters 0.
- Reset mid-burst abandons it. Stray beats arriving after reset carry an old `rid`; the cache is already in IDLE with `rready=0`, so system reset of the bus is required.

## Timing
- Hit: request accepted in cycle 0; `resp_valid` is asserted combinationally in cycle 1.
- Miss: `arvalid` asserted in cycle 2. `resp_valid` is asserted one cycle after the `rlast` handshake, giving total latency 3 + AR wait + WORDS beats.
- `resp_inst` and `resp_pc` are stable while `resp_valid && !resp_ready`.
- Only one outstanding AR transaction at any time.
- Back-to-back hits: one instruction every 2 cycles (IDLE, LOOKUP).

## Configuration
- `ICACHE_PERF_EN` defined: `hit_cnt` and `miss_cnt` increment once per LOOKUP cycle in which the lookup is resolved (hit with `resp_ready`, or miss). Killed lookups are not counted. Both counters wrap at 2^32.
- Not defined: no counter registers; `hit_cnt` and `miss_cnt` are tied to 0.

## Test plan
- Cold fetch at 0x3000_0000 with LINES=4, WORDS=4; memory returns 4 beats of 0x11,0x22,0x33,0x44 → `araddr=0x3000_0000`, `arlen=3`, `arid=1`; `resp_inst=0x11`. A refetch of 0x3000_0008 hits with `resp_inst=0x33` one cycle after acceptance.
- 0x3000_0000 followed by 0x3000_0040 (same index, different tag) → second access misses and evicts. A third fetch of 0x3000_0000 misses again (`miss_cnt=3`, `hit_cnt=0`).
- `kill` during beat 2 of a refill → remaining beats drained with `rready=1`; no `resp_valid`; line installed; the next fetch to the same line hits.
- `rresp=2'b10` on beat 1 → `resp_err=1` with `resp_valid`; the line is not installed, so a refetch issues a new AR with `arid` incremented.
- `fence_i` pulsed while in R → after completion a fetch of the same line misses. `fence_i` in IDLE gives an immediate miss on the next fetch.
- `resp_ready` held low for 5 cycles in RESP → `resp_inst` is stable throughout and `req_ready` stays 0 until the handshake.
